// File: rtl/decoder_grant_arbiter.sv
// Round-robin owner selection for a shared 4-to-16 decoded resource.
// Drives the decoder Sel/Enable pair plus a new-grant pulse and a hold counter.
// The owner may be preempted after MAX_HOLD ticked cycles when others wait.
// MAX_HOLD = 0 disables preemption.
module decoder_grant_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Tick,
    input  logic [15:0] Req,
    output logic [3:0]  GrantSel,
    output logic        GrantEnable,
    output logic        GrantStart,
    output logic [7:0]  HoldCount
);

    localparam logic [7:0] MAX_HOLD_L = 8'(MAX_HOLD);
    localparam logic       PREEMPT_EN = (MAX_HOLD != 0);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  last, last_nxt;
    logic [3:0]  sel_nxt;
    logic        en_nxt;
    logic        start_nxt;
    logic [7:0]  hold_nxt;

    logic [15:0] others;
    logic [15:0] search_req;
    logic [3:0]  search_base;
    logic [3:0]  winner;

    // First set bit of req scanning upward from base+1, wrapping at 15.
    // base itself is visited last, so it only wins when it is the sole requester.
    function automatic logic [3:0] rr_pick(input logic [15:0] req, input logic [3:0] base);
        logic [3:0] idx;
        logic [3:0] pick;
        logic       found;
        pick  = base;
        found = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            idx = base + 4'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Requests from everyone except the current owner.
    assign others = Req & ~(16'h0001 << GrantSel);

    // Search set and base: from LAST when idle, from the owner otherwise.
    // On a release the owner bit is already clear, so Req equals others.
    assign search_req  = (state == IDLE) ? Req : others;
    assign search_base = (state == IDLE) ? last : GrantSel;
    assign winner      = rr_pick(search_req, search_base);

    // Next-state and output decode: issue, release, preempt or hold.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        sel_nxt   = GrantSel;
        en_nxt    = GrantEnable;
        start_nxt = 1'b0;
        hold_nxt  = HoldCount;
        if (Tick) begin
            if (state == IDLE) begin
                if (|Req) begin
                    state_nxt = GRANT;
                    last_nxt  = winner;
                    sel_nxt   = winner;
                    en_nxt    = 1'b1;
                    start_nxt = 1'b1;
                    hold_nxt  = 8'd1;
                end
            end else if (!Req[GrantSel]) begin
                if (|others) begin
                    last_nxt  = winner;
                    sel_nxt   = winner;
                    start_nxt = 1'b1;
                    hold_nxt  = 8'd1;
                end else begin
                    state_nxt = IDLE;
                    en_nxt    = 1'b0;
                    hold_nxt  = 8'd0;
                end
            end else if (PREEMPT_EN && (HoldCount >= MAX_HOLD_L) && (|others)) begin
                last_nxt  = winner;
                sel_nxt   = winner;
                start_nxt = 1'b1;
                hold_nxt  = 8'd1;
            end else if (HoldCount != 8'hFF) begin
                hold_nxt = HoldCount + 8'd1;
            end
        end
    end

    // State, pointer and registered outputs; reset wins over Tick.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            last        <= 4'd15;
            GrantSel    <= 4'd0;
            GrantEnable <= 1'b0;
            GrantStart  <= 1'b0;
            HoldCount   <= 8'd0;
        end else begin
            state       <= state_nxt;
            last        <= last_nxt;
            GrantSel    <= sel_nxt;
            GrantEnable <= en_nxt;
            GrantStart  <= start_nxt;
            HoldCount   <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// Bench for decoder_grant_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_decoder_grant_arbiter;

    localparam int MAXH = 8;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Tick;
    logic [15:0] Req;
    logic [3:0]  GrantSel;
    logic        GrantEnable;
    logic        GrantStart;
    logic [7:0]  HoldCount;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_on = 1'b0;

    // Model state: owner as a plain integer, -1 meaning nobody holds the grant.
    int m_owner = -1;
    int m_shown = 0;
    int m_start = 0;
    int m_hold  = 0;
    int m_last  = 15;

    decoder_grant_arbiter #(.MAX_HOLD(MAXH)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Tick       (Tick),
        .Req        (Req),
        .GrantSel   (GrantSel),
        .GrantEnable(GrantEnable),
        .GrantStart (GrantStart),
        .HoldCount  (HoldCount)
    );

    always #5 Clock = ~Clock;

    // Round-robin: walk the ring starting just after base, first requester wins.
    function automatic int next_in_ring(input logic [15:0] r, input int base);
        for (int k = 1; k <= 16; k++)
            if (r[(base + k) % 16]) return (base + k) % 16;
        return -1;
    endfunction

    task automatic give_to(input int who);
        m_owner = who;
        m_shown = who;
        m_start = 1;
        m_hold  = 1;
        m_last  = who;
    endtask

    // Reference behaviour, evaluated on each rising edge from the sampled inputs.
    always @(posedge Clock) begin
        logic [15:0] waiting;
        if (Reset) begin
            m_owner = -1; m_shown = 0; m_start = 0; m_hold = 0; m_last = 15;
        end else if (!Tick) begin
            m_start = 0;
        end else if (m_owner < 0) begin
            if (Req != 0) give_to(next_in_ring(Req, m_last));
            else m_start = 0;
        end else begin
            waiting = Req;
            waiting[m_owner] = 1'b0;
            if (!Req[m_owner]) begin
                if (waiting != 0) give_to(next_in_ring(waiting, m_owner));
                else begin m_owner = -1; m_start = 0; m_hold = 0; end
            end else if (MAXH != 0 && m_hold >= MAXH && waiting != 0) begin
                give_to(next_in_ring(waiting, m_owner));
            end else begin
                m_start = 0;
                if (m_hold < 255) m_hold++;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge Clock) begin
        if (cmp_on) begin
            n_cmp++;
            if (GrantEnable !== (m_owner >= 0) || GrantSel !== 4'(m_shown) ||
                GrantStart !== (m_start != 0) || HoldCount !== 8'(m_hold)) begin
                n_fail++;
                $display("FAIL model t=%0t got en=%0b sel=%0d start=%0b hold=%0d want en=%0b sel=%0d start=%0d hold=%0d",
                         $time, GrantEnable, GrantSel, GrantStart, HoldCount,
                         (m_owner >= 0), m_shown, m_start, m_hold);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Literal check: outputs as a packed {en, sel, start, hold}.
    task automatic chk(input string name, input logic en, input logic [3:0] sel,
                       input logic st, input logic [7:0] hold);
        n_cmp++;
        if (GrantEnable !== en || GrantSel !== sel || GrantStart !== st || HoldCount !== hold) begin
            n_fail++;
            $display("FAIL %s got en=%0b sel=%0d start=%0b hold=%0d want en=%0b sel=%0d start=%0b hold=%0d",
                     name, GrantEnable, GrantSel, GrantStart, HoldCount, en, sel, st, hold);
        end
    endtask

    initial begin
        Reset = 1'b1; Tick = 1'b1; Req = 16'h0;
        step(2);
        chk("reset_state", 1'b0, 4'd0, 1'b0, 8'd0);
        cmp_on = 1'b1;

        // Single requester 0: one-cycle latency, counter climbs.
        Reset = 1'b0; Req = 16'h0001;
        step(); chk("first_grant", 1'b1, 4'd0, 1'b1, 8'd1);
        step(); chk("hold_2", 1'b1, 4'd0, 1'b0, 8'd2);
        step(); chk("hold_3", 1'b1, 4'd0, 1'b0, 8'd3);

        // 0 and 15 contend: preempt after 8 cycles, wrap back.
        Req = 16'h8001;
        step(5); chk("hold_8", 1'b1, 4'd0, 1'b0, 8'd8);
        step(); chk("preempt_to_15", 1'b1, 4'd15, 1'b1, 8'd1);
        step(7); chk("hold15_8", 1'b1, 4'd15, 1'b0, 8'd8);
        step(); chk("preempt_wrap_0", 1'b1, 4'd0, 1'b1, 8'd1);

        // Owner 3 releases with 9 and 1 waiting: search from 4 picks 9.
        Req = 16'h0000;
        step(); chk("release_idle", 1'b0, 4'd0, 1'b0, 8'd0);
        Req = 16'h0008;
        step(); chk("grant_3", 1'b1, 4'd3, 1'b1, 8'd1);
        Req = 16'h0202;
        step(); chk("handoff_9", 1'b1, 4'd9, 1'b1, 8'd1);

        // Lone requester 5: never preempted, counter saturates.
        Req = 16'h0020;
        step(); chk("grant_5", 1'b1, 4'd5, 1'b1, 8'd1);
        step(300); chk("saturate_255", 1'b1, 4'd5, 1'b0, 8'd255);
        Req = 16'h0000;
        step(); chk("drop_5", 1'b0, 4'd5, 1'b0, 8'd0);

        // Tick low freezes everything while the owner lets go.
        Req = 16'h0080;
        step(2); chk("grant_7_h2", 1'b1, 4'd7, 1'b0, 8'd2);
        Tick = 1'b0; Req = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            step(); chk("frozen", 1'b1, 4'd7, 1'b0, 8'd2);
        end
        Tick = 1'b1;
        step(); chk("thaw_release", 1'b0, 4'd7, 1'b0, 8'd0);

        // Reset mid-grant; re-arbitration restarts from index 0.
        Req = 16'h0080;
        step(); chk("grant_7", 1'b1, 4'd7, 1'b1, 8'd1);
        Req = 16'h00A0; Reset = 1'b1;
        step(); chk("mid_reset", 1'b0, 4'd0, 1'b0, 8'd0);
        Reset = 1'b0;
        step(); chk("post_reset_5", 1'b1, 4'd5, 1'b1, 8'd1);

        // Random traffic: sticky sparse requests, gated ticks, rare resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                Req = 16'($urandom) & 16'($urandom);
                if ($urandom_range(0, 3) == 0) Req = 16'h0001 << $urandom_range(0, 15);
            end
            Tick  = ($urandom_range(0, 9) != 0);
            Reset = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
